// File: rtl/registro_pipe.sv
// Elastic DEPTH-stage register pipeline with valid/ready on both sides.
// Bubbles collapse under backpressure; clr flushes valids and occupancy.
module registro_pipe #(
    parameter int unsigned      WIDTH       = 5,
    parameter int unsigned      DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             dd,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             qq,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned OW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] mv;
    logic [DEPTH-1:0] ld;
    logic             accept;
    logic             drain;

    // Move chain is resolved from the output backwards so a stage can
    // advance into a slot that is being vacated in the same cycle.
    always_comb begin
        mv          = '0;
        mv[DEPTH-1] = v[DEPTH-1] & out_ready;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            mv[DEPTH-1-k] = v[DEPTH-1-k] & (~v[DEPTH-k] | mv[DEPTH-k]);
        end
    end

    always_comb begin
        in_ready = ~clr & (~v[0] | mv[0]);
        accept   = in_valid & in_ready;
        drain    = mv[DEPTH-1];
        ld       = '0;
        ld[0]    = accept;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            ld[k] = mv[k-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v <= '0;
        end else if (clr) begin
            v <= '0;
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                v[k] <= ld[k] | (v[k] & ~mv[k]);
            end
        end
    end

    // Data loads are suppressed during clr so flushed contents stay put.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                d[k] <= RESET_VALUE;
            end
        end else if (!clr) begin
            if (ld[0]) begin
                d[0] <= dd;
            end
            for (int unsigned k = 1; k < DEPTH; k++) begin
                if (ld[k]) begin
                    d[k] <= d[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occupancy <= '0;
        end else if (clr) begin
            occupancy <= '0;
        end else begin
            unique case ({accept, drain})
                2'b10:   occupancy <= occupancy + OW'(1);
                2'b01:   occupancy <= occupancy - OW'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    assign out_valid = v[DEPTH-1];
    assign qq        = d[DEPTH-1];

endmodule

// File: tb/tb_registro_pipe.sv
// Randomized and directed bench for registro_pipe against a queue-of-words
// reference model that tracks each word's stage position.
module tb_registro_pipe;

    localparam int unsigned W = 5;
    localparam int          D = 4;

    logic         clk;
    logic         reset_n;
    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dd;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] qq;
    logic [2:0]   occupancy;

    registro_pipe #(
        .WIDTH(W),
        .DEPTH(D),
        .RESET_VALUE('0)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .clr(clr),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .dd(dd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .qq(qq),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Reference model: words oldest-first, each with its stage position.
    logic [W-1:0] m_word[$];
    int           m_pos[$];
    logic [W-1:0] m_last;   // last word to reach the output stage
    logic [W-1:0] rx[$];

    function automatic logic model_in_ready(input logic ordy, input logic c);
        int lim;
        int np;
        if (c) return 1'b0;
        if (m_pos.size() == 0) return 1'b1;
        lim = ordy ? D + 1 : D;
        np  = 0;
        foreach (m_pos[i]) begin
            np  = (m_pos[i] + 1 < lim) ? m_pos[i] + 1 : m_pos[i];
            lim = np;
        end
        return np > 0;
    endfunction

    task automatic model_step(input logic acc, input logic [W-1:0] dv,
                              input logic ordy, input logic c);
        logic [W-1:0] nw[$];
        int           npq[$];
        int           lim;
        int           np;
        lim = ordy ? D + 1 : D;
        foreach (m_pos[i]) begin
            np  = (m_pos[i] + 1 < lim) ? m_pos[i] + 1 : m_pos[i];
            lim = np;
            if (np < D) begin
                if (!c && np == D - 1 && m_pos[i] != D - 1) m_last = m_word[i];
                nw.push_back(m_word[i]);
                npq.push_back(np);
            end
        end
        if (c) begin
            m_word.delete();
            m_pos.delete();
        end else begin
            if (acc) begin
                nw.push_back(dv);
                npq.push_back(0);
                if (D == 1) m_last = dv;
            end
            m_word = nw;
            m_pos  = npq;
        end
    endtask

    task automatic step(input logic iv, input logic [W-1:0] dv, input logic ordy,
                        input logic c, output logic acc);
        logic e_ir;
        logic e_ov;
        @(negedge clk);
        in_valid  = iv;
        dd        = dv;
        out_ready = ordy;
        clr       = c;
        #1;
        e_ir = model_in_ready(ordy, c);
        e_ov = (m_pos.size() > 0) && (m_pos[0] == D - 1);
        chk("in_ready", 32'(in_ready), 32'(e_ir));
        chk("out_valid", 32'(out_valid), 32'(e_ov));
        chk("qq", 32'(qq), 32'(m_last));
        chk("occupancy", 32'(occupancy), 32'(m_word.size()));
        if (out_valid && ordy) rx.push_back(qq);
        acc = iv && e_ir;
        model_step(acc, dv, ordy, c);
    endtask

    task automatic flush_out();
        logic a;
        repeat (D + 2) step(1'b0, '0, 1'b1, 1'b0, a);
        rx.delete();
    endtask

    initial begin
        logic a;
        int   idx;
        int   lat;
        logic pv;
        logic [W-1:0] pd;

        reset_n   = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dd        = '0;
        m_last    = '0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_qq", 32'(qq), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Streaming at full rate
        rx.delete();
        for (int k = 1; k <= 8; k++) step(1'b1, W'(k), 1'b1, 1'b0, a);
        repeat (D + 1) step(1'b0, '0, 1'b1, 1'b0, a);
        chk("stream_count", 32'(rx.size()), 32'd8);
        for (int k = 0; k < rx.size() && k < 8; k++) chk("stream_word", 32'(rx[k]), 32'(k + 1));
        flush_out();

        // Backpressure fill then drain
        idx = 0;
        repeat (6) begin
            step(1'b1, W'(idx + 1), 1'b0, 1'b0, a);
            if (a) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd4);
        chk("bp_full_occ", 32'(occupancy), 32'd4);
        repeat (12) begin
            step(idx < 6, W'(idx + 1), 1'b1, 1'b0, a);
            if (a) idx++;
        end
        chk("bp_count", 32'(rx.size()), 32'd6);
        for (int k = 0; k < rx.size() && k < 6; k++) chk("bp_word", 32'(rx[k]), 32'(k + 1));
        flush_out();

        // Bubble collapse
        step(1'b1, 5'd7, 1'b0, 1'b0, a);
        step(1'b0, '0, 1'b0, 1'b0, a);
        step(1'b0, '0, 1'b0, 1'b0, a);
        step(1'b1, 5'd9, 1'b0, 1'b0, a);
        repeat (D) step(1'b0, '0, 1'b0, 1'b0, a);
        chk("bubble_occ", 32'(occupancy), 32'd2);
        step(1'b0, '0, 1'b1, 1'b0, a);
        step(1'b0, '0, 1'b1, 1'b0, a);
        chk("bubble_count", 32'(rx.size()), 32'd2);
        if (rx.size() == 2) begin
            chk("bubble_first", 32'(rx[0]), 32'd7);
            chk("bubble_second", 32'(rx[1]), 32'd9);
        end
        flush_out();

        // Flush with a word offered in the clr cycle
        for (int k = 0; k < 3; k++) step(1'b1, W'(k + 11), 1'b0, 1'b0, a);
        step(1'b1, 5'd15, 1'b0, 1'b1, a);
        chk("flush_no_accept", 32'(a), 32'd0);
        step(1'b1, 5'd20, 1'b1, 1'b0, a);
        chk("flush_occ", 32'(occupancy), 32'd0);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, '0, 1'b1, 1'b0, a);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk("flush_latency", 32'(lat), 32'(D));
        flush_out();

        // Full with simultaneous accept and drain
        for (int k = 0; k < D; k++) step(1'b1, W'(k + 1), 1'b0, 1'b0, a);
        for (int k = 0; k < 4; k++) step(1'b1, W'(k + 5), 1'b1, 1'b0, a);
        chk("full_sim_occ", 32'(occupancy), 32'(D));
        for (int k = 0; k < rx.size() && k < 4; k++) chk("full_sim_word", 32'(rx[k]), 32'(k + 1));
        flush_out();

        // Random valid/ready with occasional clr
        pv = 1'b0;
        pd = '0;
        repeat (400) begin
            if (!pv && $urandom_range(0, 2) != 0) begin
                pv = 1'b1;
                pd = W'($urandom);
            end
            step(pv, pd, 1'($urandom_range(0, 1)), $urandom_range(0, 24) == 0, a);
            if (a) pv = 1'b0;
        end
        flush_out();

        // Asynchronous reset mid-stream
        for (int k = 0; k < 3; k++) step(1'b1, W'(k + 21), 1'b0, 1'b0, a);
        @(negedge clk);
        in_valid = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_qq", 32'(qq), 32'd0);
        chk("async_occ", 32'(occupancy), 32'd0);
        m_word.delete();
        m_pos.delete();
        m_last = '0;
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0, a);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 6; k++) step(1'b1, W'(k + 3), 1'b1, 1'b0, a);
        flush_out();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
